// File: rtl/sync_evt_det.sv
// Debounced edge detector: K-sample qualification FSM, registered level and edge pulses,
// plus an optional saturating rise counter enabled by the SYNC_EVT_DET_CNT_EN macro.
module sync_evt_det #(
  parameter int FILT_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              clr_,
  input  logic              d_sync,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              cnt_clr,
  output logic              q_filt,
  output logic              rise_pls,
  output logic              fall_pls,
  output logic [CNT_W-1:0]  evt_cnt
);

  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_RISE_QUAL = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_FALL_QUAL = 2'd3;

  localparam logic [FILT_W-1:0] QCNT_ONE = {{(FILT_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [FILT_W-1:0] qcnt_q, qcnt_d;
  logic              q_filt_q, q_filt_d;
  logic              rise_pls_q, rise_pls_d;
  logic              fall_pls_q, fall_pls_d;

  logic [FILT_W-1:0] k_eff;
  logic              k_is_one;
  logic [FILT_W:0]   qcnt_plus1;
  logic              qual_done;
  logic [FILT_W-1:0] qcnt_sat_inc;

  // A programmed length of 0 behaves exactly like 1 (follow d_sync with no filtering).
  assign k_eff        = (filt_len == '0) ? QCNT_ONE : filt_len;
  assign k_is_one     = (k_eff == QCNT_ONE);
  // One extra bit so qcnt+1 cannot overflow before the compare against K.
  assign qcnt_plus1   = {1'b0, qcnt_q} + {{FILT_W{1'b0}}, 1'b1};
  assign qual_done    = (qcnt_plus1 >= {1'b0, k_eff});
  assign qcnt_sat_inc = (&qcnt_q) ? qcnt_q : qcnt_q + QCNT_ONE;

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    case (state_q)
      ST_LOW: begin
        qcnt_d = '0;
        if (d_sync) begin
          if (k_is_one) begin
            state_d = ST_HIGH;
          end else begin
            state_d = ST_RISE_QUAL;
            qcnt_d  = QCNT_ONE;
          end
        end
      end
      ST_RISE_QUAL: begin
        if (!d_sync) begin
          state_d = ST_LOW;
          qcnt_d  = '0;
        end else if (qual_done) begin
          state_d = ST_HIGH;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_sat_inc;
        end
      end
      ST_HIGH: begin
        qcnt_d = '0;
        if (!d_sync) begin
          if (k_is_one) begin
            state_d = ST_LOW;
          end else begin
            state_d = ST_FALL_QUAL;
            qcnt_d  = QCNT_ONE;
          end
        end
      end
      ST_FALL_QUAL: begin
        if (d_sync) begin
          state_d = ST_HIGH;
          qcnt_d  = '0;
        end else if (qual_done) begin
          state_d = ST_LOW;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_sat_inc;
        end
      end
      default: begin
        state_d = ST_LOW;
        qcnt_d  = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so q_filt moves on the qualifying edge.
  always_comb begin
    q_filt_d   = (state_d == ST_HIGH) || (state_d == ST_FALL_QUAL);
    rise_pls_d = ((state_q == ST_LOW) || (state_q == ST_RISE_QUAL)) && (state_d == ST_HIGH);
    fall_pls_d = ((state_q == ST_HIGH) || (state_q == ST_FALL_QUAL)) && (state_d == ST_LOW);
  end

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      state_q    <= ST_LOW;
      qcnt_q     <= '0;
      q_filt_q   <= 1'b0;
      rise_pls_q <= 1'b0;
      fall_pls_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      q_filt_q   <= q_filt_d;
      rise_pls_q <= rise_pls_d;
      fall_pls_q <= fall_pls_d;
    end
  end

  assign q_filt   = q_filt_q;
  assign rise_pls = rise_pls_q;
  assign fall_pls = fall_pls_q;

`ifdef SYNC_EVT_DET_CNT_EN
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;

  // Counts during the cycle rise_pls is high; a clear in that same cycle takes priority.
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (cnt_clr) begin
      evt_cnt_d = '0;
    end else if (rise_pls_q && !(&evt_cnt_q)) begin
      evt_cnt_d = evt_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      evt_cnt_q <= '0;
    end else begin
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign evt_cnt = evt_cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign evt_cnt        = '0;
`endif

endmodule

// File: doc/sync_evt_det.md
SYNC_EVT_DET -- requirements
Module: sync_evt_det

Interface
REQ-001 Parameter FILT_W, default 4: width of filter-length input and internal qualify counter.
REQ-002 Parameter CNT_W, default 8: width of event counter.
REQ-003 clk  input  1  the block's single clock; all state updates on its rising edge.
REQ-004 clr_  input  1  reset; asynchronous, active-low.
REQ-005 d_sync  input  1  level from the upstream 2-flop synchronizer, already in the clk domain; no further synchronization is performed.
REQ-006 filt_len  input  FILT_W  required count K of consecutive equal samples; 0 is treated as 1.
REQ-007 cnt_clr  input  1  synchronous clear of the event counter.
REQ-008 q_filt  output  1  debounced level, registered.
REQ-009 rise_pls  output  1  one-cycle pulse on a qualified 0->1 transition of q_filt, registered.
REQ-010 fall_pls  output  1  one-cycle pulse on a qualified 1->0 transition of q_filt, registered.
REQ-011 evt_cnt  output  CNT_W  saturating count of rise_pls events, registered.

Function
REQ-012 FSM states: LOW, RISE_QUAL, HIGH, FALL_QUAL; q_filt=1 only in HIGH and FALL_QUAL.
REQ-013 LOW: d_sync=0 -> stay; d_sync=1 and K=1 -> HIGH; d_sync=1 and K>1 -> RISE_QUAL with qcnt=1.
REQ-014 RISE_QUAL: d_sync=0 -> LOW, qcnt=0, no pulse; d_sync=1 and qcnt+1>=K -> HIGH, qcnt=0; else qcnt increments.
REQ-015 HIGH and FALL_QUAL mirror LOW and RISE_QUAL with d_sync polarity inverted.
REQ-016 Latency: q_filt changes on the same edge that samples the Kth consecutive new-level d_sync.
REQ-017 rise_pls asserts for exactly the one cycle following entry to HIGH from LOW or RISE_QUAL; fall_pls likewise on entry to LOW from HIGH or FALL_QUAL.
REQ-018 rise_pls and fall_pls are never asserted in the same cycle; minimum spacing between any two pulses is K cycles.
REQ-019 filt_len is sampled every cycle; a change during qualification takes effect immediately; the >= compare completes qualification if K shrinks below qcnt+1.
REQ-020 qcnt saturates at all-ones and never wraps; K=2^FILT_W-1 remains reachable.
REQ-021 Glitch shorter than K samples produces no change on q_filt and no pulse.
REQ-022 evt_cnt increments by 1 in the cycle rise_pls is high; it holds at 2^CNT_W-1 and does not wrap.
REQ-023 cnt_clr=1 sets evt_cnt to 0 on the next edge; with a simultaneous rise_pls, clear wins and the result is 0.

Reset
REQ-024 clr_ low asynchronously forces state LOW, qcnt=0, q_filt=0, rise_pls=0, fall_pls=0, evt_cnt=0.
REQ-025 Reset asserted mid-qualification discards partial count; after release, qualification restarts from LOW.
REQ-026 d_sync high at reset release is qualified as a normal rise: rise_pls fires after K samples.

Configuration
REQ-027 Macro SYNC_EVT_DET_CNT_EN: defined -> event counter implemented per REQ-022/023.
REQ-028 Macro SYNC_EVT_DET_CNT_EN undefined -> no counter flops; evt_cnt tied to 0; cnt_clr ignored; port list unchanged.

Verification
REQ-029 filt_len=3, d_sync 0->1 held -> q_filt=1 at the 3rd edge sampling 1; rise_pls high 1 cycle; evt_cnt=1.
REQ-030 filt_len=3, d_sync high for 2 cycles then low -> q_filt stays 0, no pulses, evt_cnt unchanged.
REQ-031 filt_len=0, d_sync toggling every cycle -> q_filt follows d_sync one cycle later; alternating rise_pls/fall_pls, never both high.
REQ-032 filt_len=5, after 3 high samples change filt_len to 2 -> q_filt=1 on the next edge sampling 1.
REQ-033 CNT_W=8, 260 qualified rises -> evt_cnt=255; then cnt_clr together with rise_pls -> evt_cnt=0.
REQ-034 clr_ asserted asynchronously mid-RISE_QUAL with d_sync=1 -> all outputs 0 immediately; after release with filt_len=4, rise_pls at the 4th sample.
